// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default 640x480 timing constants, RGB width and colour-bar table
// shared by video_timing_gen and video_test_pattern.
package video_timing_pkg;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int RGB_W        = 8;
   typedef logic [3*RGB_W-1:0] rgb_t;
   // left to right: white, yellow, cyan, green, magenta, red, blue, black
   localparam rgb_t BAR_COLOURS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };
endpackage

// File: rtl/video_test_pattern.sv
// video_test_pattern: eight equal-width vertical colour bars selected by the horizontal count.
module video_test_pattern
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF
) (
   input  logic [15:0]      i_h_cnt,
   output logic [RGB_W-1:0] o_red,
   output logic [RGB_W-1:0] o_green,
   output logic [RGB_W-1:0] o_blue
);
   localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);
   logic [15:0] bar;
   always_comb begin
      bar = i_h_cnt / BAR_W;
      {o_red, o_green, o_blue} = BAR_COLOURS[(bar > 16'd7) ? 3'd7 : bar[2:0]];
   end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: VGA-style raster counters with a one-cycle registered DAC stage.
// Defining VIDEO_TEST_PATTERN_EN adds i_pattern_sel and a colour-bar generator.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
`ifdef VIDEO_TEST_PATTERN_EN
   input  logic             i_pattern_sel,
`endif
   output logic [15:0]      o_x,
   output logic [15:0]      o_y,
   output logic             o_v_sync,
   output logic             o_frame_start,
   input  logic [RGB_W-1:0] i_red,
   input  logic [RGB_W-1:0] i_green,
   input  logic [RGB_W-1:0] i_blue,
   output logic             o_vga_hs,
   output logic             o_vga_vs,
   output logic             o_vga_de,
   output logic [RGB_W-1:0] o_vga_red,
   output logic [RGB_W-1:0] o_vga_green,
   output logic [RGB_W-1:0] o_vga_blue
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
   localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
   localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

   logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   rgb_t        rgb_q, rgb_d, rgb_src;
   logic        hs0, vs0, de0;

`ifdef VIDEO_TEST_PATTERN_EN
   logic [RGB_W-1:0] pat_red, pat_green, pat_blue;
   video_test_pattern #(.H_ACTIVE(H_ACTIVE)) u_pattern (
      .i_h_cnt (h_cnt_q),
      .o_red   (pat_red),
      .o_green (pat_green),
      .o_blue  (pat_blue)
   );
   assign rgb_src = i_pattern_sel ? {pat_red, pat_green, pat_blue} : {i_red, i_green, i_blue};
`else
   assign rgb_src = {i_red, i_green, i_blue};
`endif

   always_comb begin
      h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 16'd1;
      v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 16'd1;
      hs0     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      vs0     = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      de0     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_d    = hs0 ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d    = vs0 ? V_SYNC_POL : ~V_SYNC_POL;
      de_d    = de0;
      rgb_d   = de0 ? rgb_src : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         hs_q    <= ~H_SYNC_POL;
         vs_q    <= ~V_SYNC_POL;
         de_q    <= 1'b0;
         rgb_q   <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         rgb_q   <= rgb_d;
      end
   end

   assign o_x           = h_cnt_q;
   assign o_y           = v_cnt_q;
   assign o_v_sync      = vs0 ? V_SYNC_POL : ~V_SYNC_POL;
   assign o_frame_start = i_rst_n && (h_cnt_q == '0) && (v_cnt_q == '0);
   assign o_vga_hs      = hs_q;
   assign o_vga_vs      = vs_q;
   assign o_vga_de      = de_q;
   assign {o_vga_red, o_vga_green, o_vga_blue} = rgb_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench; default horizontal timing, shortened vertical
// timing so whole frames fit in the run.
module tb_video_timing_gen;
   localparam int HA = 640, HF = 16, HS = 96, HB = 48;
   localparam int VA = 20, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam logic [26:0] RST_VGA = {2'b11, 25'h0};

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic [15:0] o_x, o_y;
   logic        o_v_sync, o_frame_start;
   logic [7:0]  i_red, i_green, i_blue;
   logic        o_vga_hs, o_vga_vs, o_vga_de;
   logic [7:0]  o_vga_red, o_vga_green, o_vga_blue;
`ifdef VIDEO_TEST_PATTERN_EN
   logic        i_pattern_sel = 1'b0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (i_rst_n),
`ifdef VIDEO_TEST_PATTERN_EN
      .i_pattern_sel (i_pattern_sel),
`endif
      .o_x           (o_x),
      .o_y           (o_y),
      .o_v_sync      (o_v_sync),
      .o_frame_start (o_frame_start),
      .i_red         (i_red),
      .i_green       (i_green),
      .i_blue        (i_blue),
      .o_vga_hs      (o_vga_hs),
      .o_vga_vs      (o_vga_vs),
      .o_vga_de      (o_vga_de),
      .o_vga_red     (o_vga_red),
      .o_vga_green   (o_vga_green),
      .o_vga_blue    (o_vga_blue)
   );

   int          n_tests = 0, n_fail = 0;
   int          hm = 0, vm = 0, mode = 0, cyc = 0, last_fs = -1;
   int          max_x = 0, max_y = 0;
   logic [26:0] sb [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, got, exp, hm, vm);
      end
   endtask

   function automatic logic [26:0] exp_vga(int h, int v, logic [7:0] r, logic [7:0] g, logic [7:0] b);
      logic        de;
      logic [23:0] rgb;
      de  = (h < HA) && (v < VA);
      rgb = {r, g, b};
`ifdef VIDEO_TEST_PATTERN_EN
      if (i_pattern_sel && de) rgb = bars[h / (HA / 8)];
`endif
      return {(h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1,
              (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1,
              de, de ? rgb : 24'h0};
   endfunction

   task automatic cycle(input logic r);
      logic [26:0] e;
      logic [7:0]  rr, gg, bb;
      @(negedge clk);
      i_rst_n = r;
      #1;
      if (!r) begin
         hm = 0;
         vm = 0;
         last_fs = -1;
      end
      check("x", 64'(o_x), 64'(hm));
      check("y", 64'(o_y), 64'(vm));
      check("frame_start", 64'(o_frame_start), 64'(r && hm == 0 && vm == 0));
      check("v_sync", 64'(o_v_sync), 64'((vm >= VA + VF && vm < VA + VF + VS) ? 1'b0 : 1'b1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (!r) e = RST_VGA;
         check("vga", 64'({o_vga_hs, o_vga_vs, o_vga_de, o_vga_red, o_vga_green, o_vga_blue}), 64'(e));
      end
      if (o_frame_start) begin
         if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'(HT * VT));
         last_fs = cyc;
      end
      if (int'(o_x) > max_x) max_x = int'(o_x);
      if (int'(o_y) > max_y) max_y = int'(o_y);
      rr = mode != 0 ? 8'($urandom) : 8'hFF;
      gg = mode != 0 ? 8'($urandom) : 8'hFF;
      bb = mode != 0 ? 8'($urandom) : 8'hFF;
      if (hm == 5 && vm == 7) rr = 8'h12;
      if (hm == 6 && vm == 7) rr = 8'h34;
`ifdef VIDEO_TEST_PATTERN_EN
      i_pattern_sel = (mode != 0) && (vm == 0);
`endif
      i_red   = rr;
      i_green = gg;
      i_blue  = bb;
      sb.push_back(r ? exp_vga(hm, vm, rr, gg, bb) : RST_VGA);
      if (r) begin
         hm = (hm == HT - 1) ? 0 : hm + 1;
         if (hm == 0) vm = (vm == VT - 1) ? 0 : vm + 1;
      end
      cyc++;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_red   = '0;
      i_green = '0;
      i_blue  = '0;
      repeat (3) cycle(1'b0);
      repeat (HT * VT) cycle(1'b1);
      mode = 1;
      repeat (HT * VT + 15 * HT + 300) cycle(1'b1);
      repeat (3) cycle(1'b0);
      repeat (2000) cycle(1'b1);
      check("x_max", 64'(max_x), 64'(HT - 1));
      check("y_max", 64'(max_y), 64'(VT - 1));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
